// File: rtl/cf_math_pkg.sv
// -----------------------------------------------------------------------------
// cf_math_pkg
// Shared elaboration-time math helpers for index and counter sizing.
//
// Contents:
//   idx_width(n) : bits needed to hold an index into n items, with a minimum
//                  of one so that single-entry vectors still get a real port.
// -----------------------------------------------------------------------------
package cf_math_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running divider that emits a registered one-cycle tick once every
// DivFactor clock cycles. The first tick appears after the DivFactor-th rising
// edge following reset release. There is no enable input.
//
// Ports:
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  asynchronous active-high reset, clears cnt and tick
//   prescaled_o  out  1  registered tick
// -----------------------------------------------------------------------------
module tick_divider
    import cf_math_pkg::*;
#(
    parameter int DivFactor = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic prescaled_o
);

    localparam int              CntW   = idx_width(DivFactor);
    localparam logic [CntW-1:0] CntMax = CntW'(DivFactor - 1);

    logic [CntW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt         <= '0;
            prescaled_o <= 1'b0;
        end else if (cnt == CntMax) begin
            cnt         <= '0;
            prescaled_o <= 1'b1;
        end else begin
            cnt         <= cnt + CntW'(1);
            prescaled_o <= 1'b0;
        end
    end

endmodule

// File: rtl/guard_idx_prescale.sv
// -----------------------------------------------------------------------------
// guard_idx_prescale
// Slot allocator helper bundle:
//   - lowest-free-slot finder (trailing-zero count) built as a balanced tree
//   - one-hot to binary encoder with a multi-hot error flag
//   - free-running tick prescaler (tick_divider)
// The finder and encoder are purely combinational and ignore reset.
//
// Ports:
//   clk_i         in   1        clock, rising edge
//   rst_i         in   1        asynchronous active-high reset (prescaler only)
//   free_i        in   Width    bit i set means slot i is free
//   free_idx_o    out  IdxW     lowest set-bit index of free_i, 0 when empty
//   empty_o       out  1        free_i is all zero
//   onehot_i      in   OhWidth  one-hot match vector
//   bin_o         out  OhIdxW   OR of the indices of all set bits of onehot_i
//   onehot_err_o  out  1        more than one bit of onehot_i is set
//   prescaled_o   out  1        registered tick every DivFactor cycles
// -----------------------------------------------------------------------------
module guard_idx_prescale
    import cf_math_pkg::*;
#(
    parameter  int Width     = 8,
    parameter  int OhWidth   = 4,
    parameter  int DivFactor = 1,
    localparam int IdxW      = idx_width(Width),
    localparam int OhIdxW    = idx_width(OhWidth)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [Width-1:0]  free_i,
    output logic [IdxW-1:0]   free_idx_o,
    output logic              empty_o,
    input  logic [OhWidth-1:0] onehot_i,
    output logic [OhIdxW-1:0] bin_o,
    output logic              onehot_err_o,
    output logic              prescaled_o
);

    // Illegal parameterisations stop elaboration outright.
    if (Width < 1) begin : g_bad_width
        $fatal(1, "guard_idx_prescale: Width must be at least 1");
    end
    if (OhWidth < 1) begin : g_bad_oh_width
        $fatal(1, "guard_idx_prescale: OhWidth must be at least 1");
    end
    if (DivFactor < 1) begin : g_bad_div
        $fatal(1, "guard_idx_prescale: DivFactor must be at least 1");
    end

    // ------------------------------------------------------------------
    // Lowest-set-bit tree. The input is padded to a power of two; each
    // level halves the node count. A node carries "subtree has a set bit"
    // and the absolute index of its lowest set bit; the left (lower) child
    // wins whenever it is valid. Each level is a separate signal so there
    // is no apparent combinational feedback within one vector.
    // ------------------------------------------------------------------
    localparam int Pad = 1 << IdxW;

    logic [Pad-1:0] free_pad;
    assign free_pad = Pad'(free_i);

    // NOTE: every tree node is a continuous assign, so each output has a
    // value for all inputs and no latch can be inferred.
    for (genvar l = 0; l <= IdxW; l++) begin : g_lvl
        localparam int Nodes = Pad >> l;

        logic [Nodes-1:0] vld;
        logic [IdxW-1:0]  idx [Nodes];

        for (genvar j = 0; j < Nodes; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign vld[j] = free_pad[j];
                assign idx[j] = IdxW'(j);
            end else begin : g_merge
                assign vld[j] = g_lvl[l-1].vld[2*j] | g_lvl[l-1].vld[2*j+1];
                assign idx[j] = g_lvl[l-1].vld[2*j] ? g_lvl[l-1].idx[2*j]
                                                    : g_lvl[l-1].idx[2*j+1];
            end
        end
    end

    // With no free slot the root index would point at the top leaf; force 0.
    assign empty_o    = ~g_lvl[IdxW].vld[0];
    assign free_idx_o = g_lvl[IdxW].vld[0] ? g_lvl[IdxW].idx[0] : '0;

    // ------------------------------------------------------------------
    // One-hot encoder: output bit b is the OR of every input bit whose
    // index has bit b set. Multi-hot inputs therefore yield the OR of
    // their indices, which is the defined behaviour.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < OhIdxW; b++) begin : g_bin
        logic [OhWidth-1:0] mask;
        for (genvar i = 0; i < OhWidth; i++) begin : g_mask
            assign mask[i] = 1'((i >> b) & 1);
        end
        assign bin_o[b] = |(onehot_i & mask);
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign onehot_err_o = |(onehot_i & (onehot_i - OhWidth'(1)));

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    tick_divider #(
        .DivFactor (DivFactor)
    ) u_tick_divider (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .prescaled_o (prescaled_o)
    );

endmodule

// File: tb/tb_guard_idx_prescale.sv
// -----------------------------------------------------------------------------
// tb_guard_idx_prescale
// Two instances share the inputs: dut4 (DivFactor=4) and dut1 (DivFactor=1),
// both Width=8, OhWidth=4. Expected values are pushed to a scoreboard queue
// when stimulus is applied and popped against DUT outputs when sampled.
// -----------------------------------------------------------------------------
module tb_guard_idx_prescale;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] free;
    logic [3:0] onehot;

    logic [2:0] free_idx4, free_idx1;
    logic       empty4, empty1;
    logic [1:0] bin4, bin1;
    logic       oh_err4, oh_err1;
    logic       tick4, tick1;

    always #5 clk = ~clk;

    guard_idx_prescale #(
        .Width     (8),
        .OhWidth   (4),
        .DivFactor (4)
    ) dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .free_i       (free),
        .free_idx_o   (free_idx4),
        .empty_o      (empty4),
        .onehot_i     (onehot),
        .bin_o        (bin4),
        .onehot_err_o (oh_err4),
        .prescaled_o  (tick4)
    );

    guard_idx_prescale #(
        .Width     (8),
        .OhWidth   (4),
        .DivFactor (1)
    ) dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .free_i       (free),
        .free_idx_o   (free_idx1),
        .empty_o      (empty1),
        .onehot_i     (onehot),
        .bin_o        (bin1),
        .onehot_err_o (oh_err1),
        .prescaled_o  (tick1)
    );

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] actual);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, actual, e.val);
        end
    endtask

    // Reference models: plain loops, independent of the tree structure.
    function automatic int ref_lsb(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int ref_bin(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = r | i;
        return r;
    endfunction

    task automatic apply_free(input logic [7:0] v);
        free = v;
        push("free_idx4", 32'(ref_lsb(v)));
        push("empty4",    32'(v == 8'h00));
        push("free_idx1", 32'(ref_lsb(v)));
        push("empty1",    32'(v == 8'h00));
        #1;
        pop_check(32'(free_idx4));
        pop_check(32'(empty4));
        pop_check(32'(free_idx1));
        pop_check(32'(empty1));
    endtask

    task automatic apply_onehot(input logic [3:0] v);
        onehot = v;
        push("bin4",    32'(ref_bin(v)));
        push("oh_err4", 32'($countones(v) > 1));
        push("bin1",    32'(ref_bin(v)));
        push("oh_err1", 32'($countones(v) > 1));
        #1;
        pop_check(32'(bin4));
        pop_check(32'(oh_err4));
        pop_check(32'(bin1));
        pop_check(32'(oh_err1));
    endtask

    task automatic push_ticks(input logic t4, input logic t1);
        push("tick4", 32'(t4));
        push("tick1", 32'(t1));
    endtask

    task automatic sample_ticks();
        pop_check(32'(tick4));
        pop_check(32'(tick1));
    endtask

    // Cycle c counts rising edges since reset release; dut4 ticks on c%4==0.
    task automatic run_cycles(input int n);
        for (int c = 1; c <= n; c++) begin
            push_ticks((c % 4) == 0, 1'b1);
            @(posedge clk);
            @(negedge clk);
            sample_ticks();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 50000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        free   = 8'h00;
        onehot = 4'h0;
        #12;

        // Directed combinational vectors, applied while reset is held.
        apply_free(8'h00);
        apply_free(8'h80);
        apply_free(8'hFF);
        apply_free(8'h28);
        apply_onehot(4'b0100);
        apply_onehot(4'b0110);
        apply_onehot(4'b0000);

        // Prescaler stays low during reset.
        for (int i = 0; i < 3; i++) begin
            push_ticks(1'b0, 1'b0);
            @(negedge clk);
            sample_ticks();
        end

        // Exhaustive sweeps.
        for (int v = 0; v < 256; v++) apply_free(8'(v));
        for (int v = 0; v < 16; v++) apply_onehot(4'(v));

        // Release away from the clock edge and count 20 cycles.
        @(negedge clk);
        rst = 1'b0;
        run_cycles(20);

        // Both ticks are high here; an asynchronous reset must drop them at once.
        #1;
        rst = 1'b1;
        push_ticks(1'b0, 1'b0);
        #1;
        sample_ticks();
        for (int i = 0; i < 2; i++) begin
            push_ticks(1'b0, 1'b0);
            @(negedge clk);
            sample_ticks();
        end

        // Release, run two cycles into a period, reset mid-count.
        rst = 1'b0;
        run_cycles(2);
        #1;
        rst = 1'b1;
        push_ticks(1'b0, 1'b0);
        #1;
        sample_ticks();
        push_ticks(1'b0, 1'b0);
        @(negedge clk);
        sample_ticks();

        // Phase restarts: first dut4 pulse on the 4th edge after release.
        rst = 1'b0;
        run_cycles(8);

        // Combinational outputs keep working out of reset too.
        apply_free(8'h40);
        apply_onehot(4'b1000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
